// File: rtl/clock_period_meter.sv
// Measures the period and high phase of a slow, asynchronous sig_in in CLOCK
// cycles, one measurement per start request, with a timeout on every edge wait.
module clock_period_meter #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 2**WIDTH - 1
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic             valid,
   output logic             timeout,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE,
      DONE
   } state_t;

   localparam logic [WIDTH-1:0] TIMEOUT_COUNT = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] MAX_COUNT     = '1;

   state_t           state;
   logic [WIDTH-1:0] counter;
   logic [WIDTH-1:0] high_time_int;
   logic             fall_seen;

   logic             sync_meta;
   logic             sync_out;
   logic             sync_dly;
   logic [1:0]       fill;
   logic             primed;
   logic             rise_det;
   logic             fall_det;

   // Detection stays masked until all three flops hold post-reset samples, so a
   // sig_in that is already high at reset release never looks like a rising edge.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_meta <= 1'b0;
         sync_out  <= 1'b0;
         sync_dly  <= 1'b0;
         fill      <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the previous
         // stage's old value, which is what turns this chain into a shift register.
         sync_meta <= sig_in;
         sync_out  <= sync_meta;
         sync_dly  <= sync_out;
         if (fill != 2'd3) fill <= fill + 2'd1;
      end
   end

   assign primed   = (fill == 2'd3);
   assign rise_det = primed &  sync_out & ~sync_dly;
   assign fall_det = primed & ~sync_out &  sync_dly;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= IDLE;
         counter       <= '0;
         high_time_int <= '0;
         fall_seen     <= 1'b0;
         busy          <= 1'b0;
         valid         <= 1'b0;
         timeout       <= 1'b0;
         period        <= '0;
         high_time     <= '0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // An edge coinciding with start is consumed here, never reused by ARM.
               if (start) begin
                  state   <= ARM;
                  counter <= '0;
                  busy    <= 1'b1;
               end
            end
            ARM: begin
               if (rise_det) begin
                  state     <= MEASURE;
                  counter   <= WIDTH'(1);
                  fall_seen <= 1'b0;
               end else if (counter == TIMEOUT_COUNT) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  counter <= counter + WIDTH'(1);
               end
            end
            MEASURE: begin
               // The closing edge outranks a timeout reached in the same cycle.
               if (rise_det) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  valid     <= 1'b1;
                  period    <= counter;
                  high_time <= high_time_int;
               end else if (counter == TIMEOUT_COUNT) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  if (counter != MAX_COUNT) counter <= counter + WIDTH'(1);
                  if (fall_det && !fall_seen) begin
                     high_time_int <= counter;
                     fall_seen     <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed and randomized bench for clock_period_meter: sig_in waveforms of known
// high/low lengths are generated and the results compared with hi+lo and hi.
module tb_clock_period_meter;

   localparam int WIDTH = 8;
   localparam int TMO   = 20;

   logic             CLOCK = 1'b0;
   logic             RESET_N;
   logic             sig_in;
   logic             start;
   logic             busy;
   logic             valid;
   logic             timeout;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;

   clock_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
      .CLOCK    (CLOCK),
      .RESET_N  (RESET_N),
      .sig_in   (sig_in),
      .start    (start),
      .busy     (busy),
      .valid    (valid),
      .timeout  (timeout),
      .period   (period),
      .high_time(high_time)
   );

   always #5 CLOCK = ~CLOCK;

   int checks = 0;
   int errors = 0;
   int valid_seen = 0;
   int timeout_seen = 0;

   // Reference results: last completed measurement (hi+lo, hi).
   int exp_period = 0;
   int exp_high   = 0;

   // Waveform generator: 0 = low, 1 = high, 2 = periodic gen_hi/gen_lo,
   // 3 = hold gen_lvl for gen_hold cycles, then switch to gen_next
   // (periodic restarts at the beginning of its low phase).
   int   gen_mode = 0;
   int   gen_hi   = 2;
   int   gen_lo   = 2;
   int   gen_cnt  = 0;
   int   gen_hold = 0;
   int   gen_next = 0;
   logic gen_lvl  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLOCK);
      #1;
   endtask

   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge CLOCK);
         case (gen_mode)
            0: sig_in = 1'b0;
            1: sig_in = 1'b1;
            2: begin
               if (gen_cnt >= gen_hi + gen_lo) gen_cnt = 0;
               sig_in = (gen_cnt < gen_hi);
               gen_cnt++;
            end
            default: begin
               sig_in = gen_lvl;
               gen_hold--;
               if (gen_hold <= 0) begin
                  gen_mode = gen_next;
                  gen_cnt  = gen_hi;
               end
            end
         endcase
      end
   end

   always @(negedge CLOCK) begin
      if (valid) valid_seen++;
      if (timeout) timeout_seen++;
      if (valid || timeout) check("valid_timeout_exclusive", {31'd0, valid & timeout}, 0);
   end

   // Pulses start, then waits (bounded) for valid or timeout. n counts clock
   // edges after the edge that captured start; busy_before is busy one sample
   // ahead of the result.
   task automatic run_meas(input int budget, input bit poke, output bit got_v,
                           output bit got_t, output int n, output bit busy_before);
      got_v = 1'b0;
      got_t = 1'b0;
      n = 0;
      busy_before = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      while (n < budget) begin
         if (valid || timeout) begin
            got_v = valid;
            got_t = timeout;
            break;
         end
         busy_before = busy;
         if (poke) start = ~start;
         tick();
         n++;
      end
      start = 1'b0;
      check("result_within_bound", {31'd0, got_v | got_t}, 1);
   endtask

   task automatic expect_valid(input string name, input int hi, input int lo, input bit poke);
      bit v, t, bb;
      int n, vs;
      vs = valid_seen;
      run_meas(80, poke, v, t, n, bb);
      check({name, "_valid"}, v, 1);
      check({name, "_period"}, period, hi + lo);
      check({name, "_high"}, high_time, hi);
      check({name, "_busy_in_valid"}, busy, 0);
      check({name, "_busy_before_valid"}, bb, 1);
      exp_period = hi + lo;
      exp_high   = hi;
      repeat (poke ? 30 : 3) tick();
      check({name, "_valid_count"}, valid_seen - vs, 1);
      check({name, "_valid_dropped"}, valid, 0);
      check({name, "_period_held"}, period, exp_period);
   endtask

   task automatic expect_timeout(input string name, input int exp_n);
      bit v, t, bb;
      int n, vs;
      vs = valid_seen;
      run_meas(120, 1'b0, v, t, n, bb);
      check({name, "_timeout"}, t, 1);
      check({name, "_no_valid"}, v, 0);
      check({name, "_period_kept"}, period, exp_period);
      check({name, "_high_kept"}, high_time, exp_high);
      check({name, "_busy_low"}, busy, 0);
      if (exp_n >= 0) check({name, "_latency"}, n, exp_n);
      tick();
      check({name, "_timeout_dropped"}, timeout, 0);
      check({name, "_valid_count"}, valid_seen - vs, 0);
   endtask

   task automatic set_wave(input int hi, input int lo);
      gen_hi   = hi;
      gen_lo   = lo;
      gen_mode = 2;
      repeat (2 * (hi + lo) + 6) tick();
   endtask

   initial begin
      int hi, lo, vs, ts;
      RESET_N = 1'b0;
      start   = 1'b0;
      // sig_in high through reset release, then a 3-high/4-low wave.
      gen_hi   = 3;
      gen_lo   = 4;
      gen_lvl  = 1'b1;
      gen_hold = 10;
      gen_next = 2;
      gen_mode = 3;
      tick();
      check("reset_busy", busy, 0);
      check("reset_valid", valid, 0);
      check("reset_timeout", timeout, 0);
      check("reset_period", period, 0);
      check("reset_high", high_time, 0);
      tick();
      RESET_N = 1'b1;
      expect_valid("high_at_release", 3, 4, 1'b0);

      set_wave(2, 2);
      expect_valid("div4", 2, 2, 1'b0);

      set_wave(3, 7);
      expect_valid("h3l7_first", 3, 7, 1'b0);
      expect_valid("h3l7_again", 3, 7, 1'b0);

      // Period equal to TIMEOUT: the closing edge wins over the timeout.
      set_wave(10, 10);
      expect_valid("period_at_timeout", 10, 10, 1'b0);

      for (int i = 0; i < 6; i++) begin
         hi = $urandom_range(9, 1);
         lo = $urandom_range(9, 1);
         set_wave(hi, lo);
         expect_valid("random", hi, lo, 1'b0);
      end

      // sig_in stuck low: counter runs 0..TMO in ARM, pulse registered one edge later.
      gen_mode = 0;
      repeat (8) tick();
      expect_timeout("stuck_low", TMO + 1);

      // One rising edge, then stuck high: timeout from MEASURE.
      gen_lvl  = 1'b0;
      gen_hold = 4;
      gen_next = 1;
      gen_mode = 3;
      expect_timeout("stuck_high", -1);

      // Period one beyond TIMEOUT.
      set_wave(10, 11);
      expect_timeout("period_over_timeout", -1);

      set_wave(4, 5);
      expect_valid("start_ignored", 4, 5, 1'b1);

      // Reset pulse mid-measurement.
      set_wave(8, 9);
      gen_lvl  = 1'b0;
      gen_hold = 3;
      gen_next = 2;
      gen_mode = 3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (21) tick();
      check("pre_reset_busy", busy, 1);
      vs = valid_seen;
      ts = timeout_seen;
      #2;
      RESET_N = 1'b0;
      #1;
      check("async_reset_busy", busy, 0);
      check("async_reset_period", period, 0);
      check("async_reset_high", high_time, 0);
      check("async_reset_valid", valid, 0);
      check("async_reset_timeout", timeout, 0);
      tick();
      RESET_N = 1'b1;
      exp_period = 0;
      exp_high   = 0;
      repeat (40) tick();
      check("post_reset_no_valid", valid_seen - vs, 0);
      check("post_reset_no_timeout", timeout_seen - ts, 0);
      check("post_reset_idle", busy, 0);
      check("post_reset_period", period, 0);
      expect_valid("after_reset", 8, 9, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
